// File: rtl/display_scan_scheduler.sv
// Scan sequencer for a shared dual seven-segment bus: alternates digits with
// blanking dead-time and gates each digit enable with a 16-level duty cycle.
`timescale 1ns/1ps
module display_scan_scheduler #(
  parameter int DWELL_LOG2   = 16,
  parameter int BLANK_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] bright,
  output logic [3:0] digit_val,
  output logic       t1,
  output logic       t2,
  output logic       frame
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int CW = (DWELL_LOG2 > BW) ? DWELL_LOG2 : BW;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'({DWELL_LOG2{1'b1}});

  typedef enum logic [1:0] {
    BLANK_21 = 2'd0,
    SHOW_1   = 2'd1,
    BLANK_12 = 2'd2,
    SHOW_2   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sh1_q, sh1_d, sh2_q, sh2_d, shb_q, shb_d;
  logic          frame_q, frame_d;
  logic          on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    shb_d   = shb_q;
    frame_d = 1'b0;
    case (state_q)
      BLANK_21: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW_1;
        cnt_d   = '0;
      end
      SHOW_1: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK_12;
        cnt_d   = '0;
      end
      BLANK_12: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW_2;
        cnt_d   = '0;
      end
      SHOW_2: if (cnt_q == SHOW_LAST) begin
        // Frame boundary: the only place new display content is accepted.
        state_d = BLANK_21;
        cnt_d   = '0;
        frame_d = 1'b1;
        sh1_d   = s1;
        sh2_d   = s2;
        shb_d   = bright;
      end
      default: begin
        state_d = BLANK_21;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK_21;
      cnt_q   <= '0;
      sh1_q   <= 4'd0;
      sh2_q   <= 4'd0;
      shb_q   <= 4'd0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      shb_q   <= shb_d;
      frame_q <= frame_d;
    end
  end

  // Top four bits of the show counter give 16 equal slots; lit slots come first.
  assign on        = (cnt_q[DWELL_LOG2-1 -: 4] <= shb_q);
  assign t1        = (state_q == SHOW_1) && on;
  assign t2        = (state_q == SHOW_2) && on;
  assign digit_val = ((state_q == BLANK_21) || (state_q == SHOW_1)) ? sh1_q : sh2_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomized scoreboard bench for display_scan_scheduler: a cycle-position
// model predicts every output cycle; a monitor pops and compares at negedge.
`timescale 1ns/1ps
module tb_display_scan_scheduler;

  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int SHOW   = 1 << DW;
  localparam int PERIOD = 2 * (SHOW + BL);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s1 = 4'd0, s2 = 4'd0, bright = 4'd0;
  logic [3:0] digit_val;
  logic       t1, t2, frame;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [3:0] dv;
    logic       t1;
    logic       t2;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];

  int         t = 0;
  logic [3:0] m_sh1 = 4'd0, m_sh2 = 4'd0, m_shb = 4'd0;

  display_scan_scheduler #(.DWELL_LOG2(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .s1(s1), .s2(s2), .bright(bright),
    .digit_val(digit_val), .t1(t1), .t2(t2), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected outputs for cycle tt after reset release, from the frame layout:
  // [blank BL][digit1 SHOW][blank BL][digit2 SHOW].
  function automatic exp_t model(input int tt);
    exp_t e;
    int   p, k;
    bit   lit;
    p     = tt % PERIOD;
    e.cyc = tt;
    e.dv  = (p < BL + SHOW) ? m_sh1 : m_sh2;
    e.fr  = (p == 0) && (tt > 0);
    e.t1  = 1'b0;
    e.t2  = 1'b0;
    if (p >= BL && p < BL + SHOW) begin
      k    = p - BL;
      lit  = ((k * 16) / SHOW) <= int'(m_shb);
      e.t1 = lit;
    end else if (p >= 2 * BL + SHOW) begin
      k    = p - (2 * BL + SHOW);
      lit  = ((k * 16) / SHOW) <= int'(m_shb);
      e.t2 = lit;
    end
    return e;
  endfunction

  task automatic tick();
    exp_q.push_back(model(t));
    @(posedge clk);
    t++;
    if (t % PERIOD == 0) begin
      m_sh1 = s1;
      m_sh2 = s2;
      m_shb = bright;
    end
    #1;
  endtask

  task automatic restart();
    t     = 0;
    m_sh1 = 4'd0;
    m_sh2 = 4'd0;
    m_shb = 4'd0;
  endtask

  // Monitor: scoreboard compare plus independent frame-spacing and exclusivity checks.
  int mon_cyc = 0;
  int last_frame = -1;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      mon_cyc    = 0;
      last_frame = -1;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (digit_val !== e.dv || t1 !== e.t1 || t2 !== e.t2 || frame !== e.fr) begin
          failures++;
          $display("FAIL scan cycle=%0d got dv=%h t1=%b t2=%b frame=%b want dv=%h t1=%b t2=%b frame=%b",
                   e.cyc, digit_val, t1, t2, frame, e.dv, e.t1, e.t2, e.fr);
        end
      end
      checks++;
      if (t1 === 1'b1 && t2 === 1'b1) begin
        failures++;
        $display("FAIL exclusive cycle=%0d got t1=1 t2=1 want not both", mon_cyc);
      end
      if (frame === 1'b1) begin
        if (last_frame >= 0) begin
          checks++;
          if (mon_cyc - last_frame != PERIOD) begin
            failures++;
            $display("FAIL frame_period got %0d want %0d", mon_cyc - last_frame, PERIOD);
          end
        end
        last_frame = mon_cyc;
      end
      mon_cyc++;
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (digit_val !== 4'd0 || t1 !== 1'b0 || t2 !== 1'b0 || frame !== 1'b0) begin
      failures++;
      $display("FAIL %s got dv=%h t1=%b t2=%b frame=%b want all 0", name, digit_val, t1, t2, frame);
    end
  endtask

  initial begin
    s1 = 4'h5; s2 = 4'h6; bright = 4'h9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_idle");

    // Fixed timing pattern: first frame shows zeros, second shows 3/A at full brightness.
    s1 = 4'h3; s2 = 4'hA; bright = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    restart();
    repeat (2 * PERIOD) tick();

    bright = 4'd3;
    repeat (PERIOD) tick();
    bright = 4'd0;
    repeat (2 * PERIOD) tick();

    // New s1 arrives mid digit-1 show; must wait for the next frame boundary.
    while (t % PERIOD != BL + 8) tick();
    s1 = 4'h7;
    repeat (2 * PERIOD) tick();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s1     = 4'($urandom);
        s2     = 4'($urandom);
        bright = 4'($urandom);
      end
      tick();
    end

    // Mid-show reset: get digit 2 lit at full brightness, then pull reset between edges.
    bright = 4'hF;
    while (t % PERIOD != 0) tick();
    while (t % PERIOD != 2 * BL + SHOW + 5) tick();
    @(negedge clk); #2;
    checks++;
    if (t2 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_t2 got %b want 1", t2);
    end
    reset = 1'b0;
    #1;
    check_zero("async_reset_drop");
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    @(posedge clk); #1;
    reset = 1'b1;
    restart();
    repeat (2 * PERIOD) tick();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
